// File: rtl/piezo_pkg.sv
// Shared types and defaults for the piezo drum-pad hit scheduler.
package piezo_pkg;

  localparam int NCH_DEF         = 4;
  localparam int CH_W            = $clog2(NCH_DEF);
  localparam int HOLDOFF_CYC_DEF = 500000;   // 10 ms at 50 MHz
  localparam int LED_CYC_DEF     = 2500000;  // 50 ms at 50 MHz

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    HOLD
  } chan_state_t;

endpackage

// File: rtl/piezo_channel.sv
// One pad: 2-flop sync, rising-edge detect, IDLE/PEND/HOLD retrigger FSM, LED stretcher.
// req stays high until this pad's handshake; a strike while pending raises drop for one cycle.
module piezo_channel
  import piezo_pkg::*;
#(
  parameter int HOLDOFF_CYC = HOLDOFF_CYC_DEF,
  parameter int LED_CYC     = LED_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic drum,
  input  logic grant_ack,
  output logic req,
  output logic drop,
  output logic led
);

  localparam int HOLD_W = $clog2(HOLDOFF_CYC + 1);
  localparam int LED_W  = $clog2(LED_CYC + 1);

  logic              sync1, sync2, prev;
  logic              edge_det;
  chan_state_t       state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [LED_W-1:0]  led_cnt, led_nxt;

  assign edge_det = sync2 & ~prev;
  assign req      = (state == PEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      prev     <= 1'b0;
      state    <= IDLE;
      hold_cnt <= '0;
      led_cnt  <= '0;
      led      <= 1'b0;
    end else begin
      sync1    <= drum;
      sync2    <= sync1;
      prev     <= sync2;
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      led_cnt  <= led_nxt;
      led      <= (led_nxt != '0);
    end
  end

  // A strike landing in the handshake cycle falls into HOLD and is ignored.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    drop      = 1'b0;
    case (state)
      IDLE: if (edge_det) state_nxt = PEND;
      PEND: begin
        if (grant_ack) begin
          state_nxt = HOLD;
          hold_nxt  = HOLD_W'(HOLDOFF_CYC);
        end else if (edge_det) begin
          drop = 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt <= HOLD_W'(1)) begin
          state_nxt = IDLE;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_cnt - HOLD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    led_nxt = led_cnt;
    if (grant_ack)            led_nxt = LED_W'(LED_CYC);
    else if (led_cnt != '0)   led_nxt = led_cnt - LED_W'(1);
  end

endmodule

// File: rtl/piezo_hit_scheduler.sv
// Per-pad strike conditioning, round-robin serialisation onto a registered valid/ready hit stage.
// Strike to hit_valid in 4 clk edges; hit held stable until hit_ready; PIEZO_HIT_CNT_EN adds hit_cnt.
module piezo_hit_scheduler
  import piezo_pkg::*;
#(
  parameter int NCH         = NCH_DEF,
  parameter int HOLDOFF_CYC = HOLDOFF_CYC_DEF,
  parameter int LED_CYC     = LED_CYC_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCH-1:0]          drum,
  output logic                    hit_valid,
  input  logic                    hit_ready,
  output logic [$clog2(NCH)-1:0]  hit_ch,
  output logic                    overrun,
  output logic [NCH-1:0]          led
`ifdef PIEZO_HIT_CNT_EN
  ,
  input  logic                    hit_cnt_clr,
  output logic [15:0]             hit_cnt
`endif
);

  localparam int SEL_W = $clog2(NCH);

  logic [NCH-1:0]   req, drop, grant_ack;
  logic             handshake, load, sel_vld;
  logic [SEL_W-1:0] sel, idx, rr_ptr;

  assign handshake = hit_valid & hit_ready;
  assign load      = ~hit_valid | handshake;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign grant_ack[i] = handshake && (hit_ch == SEL_W'(i));

    piezo_channel #(
      .HOLDOFF_CYC(HOLDOFF_CYC),
      .LED_CYC    (LED_CYC)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .drum     (drum[i]),
      .grant_ack(grant_ack[i]),
      .req      (req[i]),
      .drop     (drop[i]),
      .led      (led[i])
    );
  end

  // The pad being accepted this cycle still shows req, so it is masked out of the search.
  always_comb begin
    sel_vld = 1'b0;
    sel     = '0;
    idx     = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = SEL_W'((int'(rr_ptr) + k) % NCH);
      if (!sel_vld && req[idx] && !grant_ack[idx]) begin
        sel_vld = 1'b1;
        sel     = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_valid <= 1'b0;
      hit_ch    <= '0;
      rr_ptr    <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= |drop;
      if (load) begin
        hit_valid <= sel_vld;
        if (sel_vld) begin
          hit_ch <= sel;
          rr_ptr <= (int'(sel) == NCH - 1) ? '0 : sel + SEL_W'(1);
        end
      end
    end
  end

`ifdef PIEZO_HIT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               hit_cnt <= '0;
    else if (hit_cnt_clr)                     hit_cnt <= '0;
    else if (handshake && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_piezo_hit_scheduler.sv
// Directed bench for piezo_hit_scheduler with a timestamp-based reference model checked every cycle.
module tb_piezo_hit_scheduler;

  localparam int NCH = 4;
  localparam int H   = 8;
  localparam int L   = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] drum = '0;
  logic           hit_ready = 1'b1;
  logic           hit_valid;
  logic [1:0]     hit_ch;
  logic           overrun;
  logic [NCH-1:0] led;
`ifdef PIEZO_HIT_CNT_EN
  logic           hit_cnt_clr = 1'b0;
  logic [15:0]    hit_cnt;
`endif

  piezo_hit_scheduler #(
    .NCH(NCH), .HOLDOFF_CYC(H), .LED_CYC(L)
  ) dut (
    .clk(clk), .rst_n(rst_n), .drum(drum),
    .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_ch(hit_ch),
    .overrun(overrun), .led(led)
`ifdef PIEZO_HIT_CNT_EN
    , .hit_cnt_clr(hit_cnt_clr), .hit_cnt(hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: raw samples by cycle, strikes derived from sample history,
  // holdoff and LED expressed as absolute cycle deadlines.
  logic [NCH-1:0] samp [0:4095];
  int  cyc = 0;
  int  rfirst = 1;
  bit  rpend = 1'b1;
  bit  pend [NCH];
  int  lock_until [NCH];
  int  led_off [NCH];
  bit  m_vld = 1'b0;
  int  m_ch = 0;
  int  rr = 0;
  bit  m_ovr = 1'b0;

  function automatic bit smp(input int i, input int k);
    if (k < rfirst) return 1'b0;
    return samp[k][i];
  endfunction

  always @(posedge clk) begin
    bit hs, found, s;
    int hc, selp, p;
    if (!rst_n) begin
      rpend = 1'b1;
      m_vld = 1'b0; m_ch = 0; rr = 0; m_ovr = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        pend[i] = 1'b0; lock_until[i] = 0; led_off[i] = 0;
      end
    end else begin
      cyc++;
      samp[cyc] = drum;
      if (rpend) begin rfirst = cyc; rpend = 1'b0; end
      hs = m_vld && hit_ready;
      hc = m_ch;
      if (!m_vld || hs) begin
        found = 1'b0; selp = 0;
        for (int k = 0; k < NCH; k++) begin
          p = (rr + k) % NCH;
          if (!found && pend[p] && !(hs && p == hc)) begin found = 1'b1; selp = p; end
        end
        if (found) begin m_vld = 1'b1; m_ch = selp; rr = (selp + 1) % NCH; end
        else m_vld = 1'b0;
      end
      m_ovr = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        s = smp(i, cyc - 2) && !smp(i, cyc - 3);
        if (hs && hc == i) begin
          pend[i] = 1'b0; lock_until[i] = cyc + H + 1; led_off[i] = cyc + L;
        end else if (pend[i]) begin
          if (s) m_ovr = 1'b1;
        end else if (s && cyc >= lock_until[i]) begin
          pend[i] = 1'b1;
        end
      end
    end
  end

  int ev_ch[$];
  int ev_cyc[$];
  int ovr_cnt = 0;
  int first, ledn, ok, stable;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_run(input int s2, input int exp_n);
    ev_ch.delete(); ev_cyc.delete();
    drum = 4'b1000;
    for (int k = 1; k <= 30; k++) begin
      step();
      drum = (k == 7 || k == s2 - 1) ? 4'b1000 : 4'b0000;
    end
    chk($sformatf("holdoff_events_s%0d", s2), ev_ch.size(), exp_n);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          chk("hit_valid", hit_valid, m_vld);
          if (m_vld) chk("hit_ch", hit_ch, m_ch);
          chk("overrun", overrun, m_ovr);
          for (int i = 0; i < NCH; i++)
            chk($sformatf("led%0d", i), led[i], (cyc < led_off[i]) ? 1 : 0);
          if (hit_valid && hit_ready) begin
            ev_ch.push_back(hit_ch);
            ev_cyc.push_back(cyc);
          end
          if (overrun) ovr_cnt++;
        end
      end
    join_none

    repeat (3) step();
    chk("reset_hit_valid", hit_valid, 0);
    chk("reset_hit_ch", hit_ch, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_led", led, 0);
    rst_n = 1'b1;
    repeat (3) step();

    // Simultaneous strikes, twice: both bursts start at pad 0.
    for (int b = 0; b < 2; b++) begin
      ev_ch.delete(); ev_cyc.delete();
      drum = 4'hF;
      step();
      drum = 4'h0;
      repeat (20) step();
      chk($sformatf("burst%0d_count", b), ev_ch.size(), 4);
      for (int j = 0; j < ev_ch.size() && j < 4; j++) begin
        chk($sformatf("burst%0d_ch%0d", b, j), ev_ch[j], j);
        chk($sformatf("burst%0d_gap%0d", b, j), ev_cyc[j] - ev_cyc[0], j);
      end
    end

    // Single held strike on pad 2.
    ev_ch.delete(); ev_cyc.delete();
    drum = 4'b0100;
    first = 0; ledn = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (hit_valid && first == 0) first = k;
      if (led[2]) ledn++;
    end
    drum = 4'b0000;
    chk("single_latency_edges", first, 4);
    chk("single_led_cycles", ledn, 4);
    chk("single_count", ev_ch.size(), 1);
    chk("single_ch", (ev_ch.size() > 0) ? ev_ch[0] : -1, 2);
    repeat (12) step();

    // Backpressure with a dropped re-strike on the pending pad.
    ev_ch.delete(); ev_cyc.delete(); ovr_cnt = 0;
    hit_ready = 1'b0;
    drum = 4'b0010;
    for (int k = 0; k < 10 && !hit_valid; k++) step();
    chk("bp_valid_seen", hit_valid, 1);
    stable = 1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (!(hit_valid && hit_ch == 2'd1)) stable = 0;
      if (k == 1) drum = 4'b0000;
      if (k == 4) drum = 4'b0010;
    end
    chk("bp_stable", stable, 1);
    drum = 4'b0000;
    hit_ready = 1'b1;
    repeat (6) step();
    chk("bp_count", ev_ch.size(), 1);
    chk("bp_ch", (ev_ch.size() > 0) ? ev_ch[0] : -1, 1);
    chk("bp_overrun_pulses", ovr_cnt, 1);
    repeat (12) step();

    // Holdoff boundary on pad 3: T+5 and T+8 ignored, T+9 accepted.
    hold_run(12, 2);
    hold_run(11, 1);

    // Asynchronous reset while a hit is presented and an LED is lit.
    drum = 4'b0011;
    ok = 0;
    for (int k = 0; k < 12 && ok == 0; k++) begin
      step();
      if (hit_valid && hit_ch == 2'd1) ok = 1;
    end
    hit_ready = 1'b0;
    chk("rst_pre_valid", ok, 1);
    chk("rst_pre_led0", led[0], 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", hit_valid, 0);
    chk("rst_async_led", led, 0);
    chk("rst_async_overrun", overrun, 0);
    drum = 4'b0000;
    hit_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    ev_ch.delete(); ev_cyc.delete();
    repeat (15) step();
    chk("rst_no_stale_event", ev_ch.size(), 0);

`ifdef PIEZO_HIT_CNT_EN
    chk("cnt_after_reset", hit_cnt, 0);
    drum = 4'b0111;
    step();
    drum = 4'b0000;
    repeat (20) step();
    chk("cnt_three_hits", hit_cnt, 3);
    drum = 4'b0001;
    for (int k = 0; k < 10 && !hit_valid; k++) step();
    hit_cnt_clr = 1'b1;
    step();
    hit_cnt_clr = 1'b0;
    drum = 4'b0000;
    chk("cnt_clr_priority", hit_cnt, 0);
    repeat (12) step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
